// File: rtl/cell_exit_scheduler.sv
// Round-robin exit scheduler: grants up to two valid cells per cycle into one pair-FIFO word,
// honours FIFO almost-full, and appends a terminator record once a drain completes.
//
// state | meaning
// IDLE  | waiting for a drain start pulse
// SCAN  | granting valid cells into FIFO words
// TERM  | writing the terminator record
// DONE  | one-cycle completion pulse, then back to IDLE
module cell_exit_scheduler #(
    parameter int N_CELL = 27,
    parameter int REC_W  = 97,
    parameter int CNT_W  = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [N_CELL-1:0]         i_cell_valid,
    input  logic [REC_W*N_CELL-1:0]   i_cell_data,
    output logic [N_CELL-1:0]         o_cell_ready,
    input  logic                      i_cells_done,
    input  logic                      i_drain_start,
    input  logic                      i_fifo_afull,
    output logic                      o_fifo_wr_en,
    output logic [2*REC_W+1:0]        o_fifo_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [CNT_W-1:0]          o_rec_count
);

    localparam int PTR_W = $clog2(N_CELL);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_TERM, ST_DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt, last_idx, idx, g0, g1;
    logic [PTR_W:0]     sum;
    logic               have0, have1, scan_ok, gnt0, gnt1;
    logic [REC_W-1:0]   rec0, rec1;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;

    // Walk the valids starting at ptr; first hit is g0, second is g1.
    always_comb begin
        g0    = '0;
        g1    = '0;
        have0 = 1'b0;
        have1 = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_CELL; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N_CELL))
                sum = sum - (PTR_W+1)'(N_CELL);
            idx = sum[PTR_W-1:0];
            if (i_cell_valid[idx]) begin
                if (!have0) begin
                    have0 = 1'b1;
                    g0    = idx;
                end else if (!have1) begin
                    have1 = 1'b1;
                    g1    = idx;
                end
            end
        end
    end

    // Grants are suppressed while reset is held so no record is popped into a discarded word.
    assign scan_ok = (state == ST_SCAN) && !i_fifo_afull && ap_rst_n;
    assign gnt0    = scan_ok && have0;
    assign gnt1    = scan_ok && have1;

    always_comb begin
        o_cell_ready = '0;
        if (gnt0) o_cell_ready = o_cell_ready | (N_CELL'(1) << g0);
        if (gnt1) o_cell_ready = o_cell_ready | (N_CELL'(1) << g1);
    end

    assign rec0     = i_cell_data[REC_W*g0 +: REC_W];
    assign rec1     = gnt1 ? i_cell_data[REC_W*g1 +: REC_W] : '0;
    assign last_idx = gnt1 ? g1 : g0;
    assign ptr_nxt  = (last_idx == PTR_W'(N_CELL-1)) ? '0 : last_idx + PTR_W'(1);

    assign cnt_sum = {1'b0, o_rec_count} + (CNT_W+1)'(gnt0) + (CNT_W+1)'(gnt1);
    assign cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_drain_start) state_nxt = ST_SCAN;
            ST_SCAN: if (i_cells_done && !(|i_cell_valid) && !i_fifo_afull) state_nxt = ST_TERM;
            ST_TERM: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            o_fifo_wr_en <= 1'b0;
            o_fifo_data  <= '0;
            o_rec_count  <= '0;
        end else begin
            state        <= state_nxt;
            o_fifo_wr_en <= 1'b0;
            if (state == ST_IDLE && i_drain_start)
                o_rec_count <= '0;
            if (gnt0) begin
                o_fifo_wr_en <= 1'b1;
                o_fifo_data  <= {gnt1, 1'b1, rec1, rec0};
                ptr          <= ptr_nxt;
                o_rec_count  <= cnt_sat;
            end
            if (state == ST_TERM) begin
                o_fifo_wr_en <= 1'b1;
                o_fifo_data  <= {1'b0, 1'b1, {REC_W{1'b0}}, 1'b1, {(REC_W-1){1'b0}}};
            end
            if (state == ST_DONE)
                ptr <= '0;
        end
    end

endmodule
